// File: rtl/link_scatter_pkg.sv
// Shared layout of the compute link word, the scatter message and the scatter FSM states.
package link_scatter_pkg;

  // Field order gives data_ptr [95:64], data_size [63:32], g_update [31:0].
  typedef struct packed {
    logic [31:0] data_ptr;
    logic [31:0] data_size;
    logic [31:0] g_update;
  } link_word_t;

  // Message order gives g_update [63:32], neighbour key [31:0].
  typedef struct packed {
    logic [31:0] g_update;
    logic [31:0] key;
  } msg_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PARSE,
    ISSUE,
    WAIT_RESP
  } scatter_state_t;

endpackage

// File: rtl/link_scatter_buf.sv
// scatter_buf: show-ahead synchronous FIFO that holds link-memory responses until they drain.
module scatter_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (usedw == (AW+1)'(DEPTH));
  assign empty   = (usedw == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   usedw <= usedw + (AW+1)'(1);
        2'b01:   usedw <= usedw - (AW+1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end
endmodule

// File: rtl/link_scatter.sv
// link_scatter: walks compute link entries, burst-reads neighbour keys and emits {g_update, key} messages.
module link_scatter
  import link_scatter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [95:0]                  compute_link_fifo_q,
  input  logic                         compute_link_fifo_empty,
  output logic                         compute_link_fifo_rdreq,
  output logic [31:0]                  link_mem_address,
  output logic                         link_mem_read,
  output logic [$clog2(MAX_BURST):0]   link_mem_burstcount,
  input  logic                         link_mem_waitrequest,
  input  logic [31:0]                  link_mem_readdata,
  input  logic                         link_mem_readdatavalid,
  output logic [63:0]                  msg_fifo_data,
  output logic                         msg_fifo_wrreq,
  input  logic                         msg_fifo_full,
  output logic                         busy
);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned OW = $clog2(BUF_DEPTH) + 1;

  scatter_state_t state, state_next;
  link_word_t     link_word;
  msg_t           resp_msg;
  logic [31:0]    ptr, remaining, g_update;
  logic [BW-1:0]  blen;
  logic [OW-1:0]  outstanding, usedw, credits;
  logic [63:0]    buf_head;
  logic           accept, resp_push, buf_pop, buf_full, buf_empty, credit_ok;

  assign link_word = compute_link_fifo_q;
  assign resp_msg  = '{g_update: g_update, key: link_mem_readdata};
  assign blen      = (remaining < MAX_BURST) ? remaining[BW-1:0] : BW'(MAX_BURST);
  // Words already requested still need a slot, so they count against the buffer.
  assign credits   = OW'(BUF_DEPTH) - usedw - outstanding;
  assign credit_ok = !buf_full && (credits >= OW'(blen));
  assign accept    = link_mem_read && !link_mem_waitrequest;
  assign resp_push = link_mem_readdatavalid && (outstanding != '0);
  assign buf_pop   = !buf_empty && !msg_fifo_full;
  assign busy      = (state != IDLE) || !buf_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next              = state;
    compute_link_fifo_rdreq = 1'b0;
    case (state)
      IDLE: begin
        if (!compute_link_fifo_empty) begin
          compute_link_fifo_rdreq = 1'b1;
          state_next              = FETCH;
        end
      end
      FETCH:     state_next = PARSE;
      PARSE:     state_next = (link_word.data_size == '0) ? IDLE : ISSUE;
      ISSUE:     if (accept && (remaining == 32'(blen))) state_next = WAIT_RESP;
      WAIT_RESP: if (outstanding == '0) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr                 <= '0;
      remaining           <= '0;
      g_update            <= '0;
      link_mem_read       <= 1'b0;
      link_mem_address    <= '0;
      link_mem_burstcount <= '0;
      outstanding         <= '0;
      msg_fifo_wrreq      <= 1'b0;
      msg_fifo_data       <= '0;
    end else begin
      if (state == PARSE) begin
        ptr       <= link_word.data_ptr;
        remaining <= link_word.data_size;
        g_update  <= link_word.g_update;
      end
      if (accept) begin
        link_mem_read <= 1'b0;
        ptr           <= ptr + (32'(blen) << 2);
        remaining     <= remaining - 32'(blen);
      end else if ((state == ISSUE) && !link_mem_read && credit_ok) begin
        link_mem_read       <= 1'b1;
        link_mem_address    <= ptr;
        link_mem_burstcount <= blen;
      end
      outstanding    <= outstanding + (accept ? OW'(blen) : '0) - (resp_push ? OW'(1) : '0);
      msg_fifo_wrreq <= buf_pop;
      if (buf_pop) msg_fifo_data <= buf_head;
    end
  end

  scatter_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (resp_push),
    .wdata (resp_msg),
    .pop   (buf_pop),
    .head  (buf_head),
    .usedw (usedw),
    .full  (buf_full),
    .empty (buf_empty)
  );
endmodule

// File: tb/tb_link_scatter.sv
// Scoreboard bench for link_scatter: link FIFO, link memory and message sink models.
module tb_link_scatter;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned BUF_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] compute_link_fifo_q;
  logic        compute_link_fifo_empty;
  logic        compute_link_fifo_rdreq;
  logic [31:0] link_mem_address;
  logic        link_mem_read;
  logic [3:0]  link_mem_burstcount;
  logic        link_mem_waitrequest;
  logic [31:0] link_mem_readdata;
  logic        link_mem_readdatavalid;
  logic [63:0] msg_fifo_data;
  logic        msg_fifo_wrreq;
  logic        msg_fifo_full;
  logic        busy;

  link_scatter #(
    .MAX_BURST (MAX_BURST),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .compute_link_fifo_q     (compute_link_fifo_q),
    .compute_link_fifo_empty (compute_link_fifo_empty),
    .compute_link_fifo_rdreq (compute_link_fifo_rdreq),
    .link_mem_address        (link_mem_address),
    .link_mem_read           (link_mem_read),
    .link_mem_burstcount     (link_mem_burstcount),
    .link_mem_waitrequest    (link_mem_waitrequest),
    .link_mem_readdata       (link_mem_readdata),
    .link_mem_readdatavalid  (link_mem_readdatavalid),
    .msg_fifo_data           (msg_fifo_data),
    .msg_fifo_wrreq          (msg_fifo_wrreq),
    .msg_fifo_full           (msg_fifo_full),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
  } burst_t;

  burst_t      exp_burst[$];
  logic [63:0] exp_msg[$];
  logic [95:0] comp_q[$];
  logic [31:0] resp_q[$];

  int unsigned checks = 0, failures = 0;
  int unsigned stall_len = 0, stale_n = 0;
  int unsigned accepted_words = 0, accepted_bursts = 0, read_cycles = 0, msg_count = 0;
  bit          resp_en = 1'b1, rand_gaps = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] key_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Queue the link entry and derive the bursts and messages it must produce.
  task automatic push_entry(input logic [31:0] p, input logic [31:0] size, input logic [31:0] g);
    logic [31:0] rem, cur, b;
    rem = size;
    cur = p;
    comp_q.push_back({p, size, g});
    while (rem != 0) begin
      b = (rem < MAX_BURST) ? rem : MAX_BURST;
      exp_burst.push_back('{addr: cur, len: b});
      for (int unsigned i = 0; i < b; i++) exp_msg.push_back({g, key_of(cur + 4 * i)});
      cur = cur + 4 * b;
      rem = rem - b;
    end
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(busy == 1'b0 && exp_msg.size() == 0 && exp_burst.size() == 0 &&
             comp_q.size() == 0 && compute_link_fifo_empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_eq({tag, "_done"}, 64'(n < budget), 1);
    check_eq({tag, "_msgs_left"}, exp_msg.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rdreq"}, compute_link_fifo_rdreq, 0);
    check_eq({tag, "_read"}, link_mem_read, 0);
    check_eq({tag, "_addr"}, link_mem_address, 0);
    check_eq({tag, "_bc"}, link_mem_burstcount, 0);
    check_eq({tag, "_wrreq"}, msg_fifo_wrreq, 0);
    check_eq({tag, "_data"}, msg_fifo_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // Link FIFO model: q updates the cycle after rdreq.
  initial begin : comp_model
    bit take;
    compute_link_fifo_empty = 1'b1;
    compute_link_fifo_q     = '0;
    forever begin
      @(negedge clk);
      take = compute_link_fifo_rdreq && !reset;
      @(posedge clk);
      #1;
      if (take && comp_q.size() > 0) compute_link_fifo_q = comp_q.pop_front();
      compute_link_fifo_empty = (comp_q.size() == 0);
    end
  end

  // Link memory model: optional waitrequest stall, in-order responses.
  initial begin : mem_model
    int unsigned stall_cnt;
    logic [31:0] held_addr;
    logic [3:0]  held_bc;
    burst_t      e;
    stall_cnt              = 0;
    held_addr              = '0;
    held_bc                = '0;
    link_mem_waitrequest   = 1'b0;
    link_mem_readdatavalid = 1'b0;
    link_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      if (link_mem_read) read_cycles++;
      if (stale_n > 0) begin
        link_mem_readdatavalid = 1'b1;
        link_mem_readdata      = 32'hDEAD_BEEF;
        stale_n--;
      end else if (resp_en && resp_q.size() > 0 && !(rand_gaps && $urandom_range(0, 2) == 0)) begin
        link_mem_readdatavalid = 1'b1;
        link_mem_readdata      = resp_q.pop_front();
      end else begin
        link_mem_readdatavalid = 1'b0;
      end
      if (stall_cnt > 0) begin
        check_eq("wait_hold_read", link_mem_read, 1);
        check_eq("wait_hold_addr", link_mem_address, held_addr);
        check_eq("wait_hold_bc", link_mem_burstcount, held_bc);
      end
      if (link_mem_read && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          held_addr = link_mem_address;
          held_bc   = link_mem_burstcount;
        end
        stall_cnt++;
        link_mem_waitrequest = 1'b1;
      end else begin
        link_mem_waitrequest = 1'b0;
        if (link_mem_read) begin
          stall_cnt = 0;
          accepted_bursts++;
          accepted_words += link_mem_burstcount;
          check_eq("burst_pending", 64'(exp_burst.size() != 0), 1);
          if (exp_burst.size() != 0) begin
            e = exp_burst.pop_front();
            check_eq("burst_addr", link_mem_address, e.addr);
            check_eq("burst_len", link_mem_burstcount, e.len);
          end
          for (int unsigned i = 0; i < link_mem_burstcount; i++)
            resp_q.push_back(key_of(link_mem_address + 4 * i));
        end
      end
    end
  end

  // Message sink: every write is matched against the scoreboard in order.
  initial begin : msg_model
    logic [63:0] m;
    forever begin
      @(negedge clk);
      if (msg_fifo_wrreq) begin
        msg_count++;
        check_eq("msg_pending", 64'(exp_msg.size() != 0), 1);
        if (exp_msg.size() != 0) begin
          m = exp_msg.pop_front();
          check_eq("msg_data", msg_fifo_data, m);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned b0, w0, r0, m0, n;
    reset         = 1'b1;
    msg_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single short burst.
    b0 = accepted_bursts; m0 = msg_count;
    push_entry(32'h0000_0100, 3, 32'h3F00_0000);
    wait_done("t1", 200);
    check_eq("t1_bursts", accepted_bursts - b0, 1);
    check_eq("t1_msgs", msg_count - m0, 3);

    // 8/8/4 split.
    b0 = accepted_bursts; m0 = msg_count;
    push_entry(32'h0000_1000, 20, 32'hBF80_1234);
    wait_done("t2", 400);
    check_eq("t2_bursts", accepted_bursts - b0, 3);
    check_eq("t2_msgs", msg_count - m0, 20);

    // Empty entry: consumed with no memory access.
    r0 = read_cycles; m0 = msg_count;
    push_entry(32'h0000_2000, 0, 32'h1234_5678);
    n = 0;
    while (!compute_link_fifo_rdreq && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_rdreq_seen", 64'(n < 20), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 10);
    check_eq("t3_idle_within_3", 64'(n <= 3), 1);
    wait_done("t3", 50);
    check_eq("t3_no_read", read_cycles - r0, 0);
    check_eq("t3_no_msg", msg_count - m0, 0);

    // waitrequest held for 5 cycles.
    r0 = read_cycles;
    stall_len = 5;
    push_entry(32'h3000_0040, 5, 32'h4049_0FDB);
    wait_done("t4", 200);
    stall_len = 0;
    check_eq("t4_read_cycles", read_cycles - r0, 6);

    // Back-pressure: issue stops at buffer capacity, nothing lost.
    w0 = accepted_words; m0 = msg_count;
    msg_fifo_full = 1'b1;
    push_entry(32'h0000_4000, 40, 32'hC2C8_0000);
    repeat (80) @(negedge clk);
    check_eq("t5_words_at_stall", accepted_words - w0, BUF_DEPTH);
    check_eq("t5_read_idle", link_mem_read, 0);
    check_eq("t5_no_msg", msg_count - m0, 0);
    check_eq("t5_busy", busy, 1);
    @(posedge clk);
    #1;
    msg_fifo_full = 1'b0;
    wait_done("t5", 800);
    check_eq("t5_words", accepted_words - w0, 40);
    check_eq("t5_msgs", msg_count - m0, 40);

    // Address wrap at the top of the 32-bit space.
    push_entry(32'hFFFF_FFF0, 10, 32'h0000_0001);
    wait_done("t6", 300);

    // Several entries back to back with irregular response spacing.
    rand_gaps = 1'b1;
    m0 = msg_count;
    n  = 0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sz;
      sz = $urandom_range(1, 30);
      n  = n + sz;
      push_entry({$urandom_range(0, 32'hFFFF), 16'h0}, sz, $urandom);
    end
    wait_done("t7", 3000);
    check_eq("t7_msgs", msg_count - m0, n);
    rand_gaps = 1'b0;

    // Reset during the second burst, then stale responses.
    b0 = accepted_bursts;
    push_entry(32'h0000_5000, 20, 32'h7777_0000);
    n = 0;
    while (accepted_bursts - b0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t8_second_burst", 64'(n < 200), 1);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    resp_en = 1'b0;
    resp_q.delete();
    exp_msg.delete();
    exp_burst.delete();
    #1;
    check_idle_outputs("t8_in_reset");
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    stale_n = 2;
    r0 = read_cycles; m0 = msg_count;
    repeat (20) @(negedge clk);
    check_eq("t8_stale_consumed", stale_n, 0);
    check_eq("t8_no_msg", msg_count - m0, 0);
    check_eq("t8_no_read", read_cycles - r0, 0);
    check_idle_outputs("t8_after");
    resp_en = 1'b1;

    // Normal operation after the reset.
    m0 = msg_count;
    push_entry(32'h0000_6000, 4, 32'h4120_0000);
    wait_done("t9", 200);
    check_eq("t9_msgs", msg_count - m0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
